// File: rtl/frac_div_pkg.sv
// Shared types for the fractional-N clock-enable generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package frac_div_pkg;

    // Default width of ratio operands, quotient, remainder and period counter
    localparam int DEF_W = 8;

    // Controller sequencing: accept -> validate -> divide -> wait for period end -> apply
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_CALC     = 3'd2,
        ST_WAIT_BND = 3'd3,
        ST_APPLY    = 3'd4
    } state_e;

endpackage

// File: rtl/frac_div_ctrl_if.sv
// Config handshake, status and pulse output of the fractional-N enable generator.
// Latency: n/a (wiring only).
// Backpressure: cfg_valid/cfg_ready; the slave holds cfg_ready low while busy.
// Optional FRAC_DIV_CTRL_STATUS_EN adds pulse_cnt and cur_q status signals.
interface frac_div_ctrl_if #(
    parameter int W = frac_div_pkg::DEF_W
);
    logic         enable;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_src_num;
    logic [W-1:0] cfg_dst_num;
    logic         cfg_err;
    logic         busy;
    logic         cfg_loaded;
    logic         clk_en_out;
`ifdef FRAC_DIV_CTRL_STATUS_EN
    logic [15:0]  pulse_cnt;
    logic [W-1:0] cur_q;

    modport master (
        output enable, cfg_valid, cfg_src_num, cfg_dst_num,
        input  cfg_ready, cfg_err, busy, cfg_loaded, clk_en_out, pulse_cnt, cur_q
    );
    modport slave (
        input  enable, cfg_valid, cfg_src_num, cfg_dst_num,
        output cfg_ready, cfg_err, busy, cfg_loaded, clk_en_out, pulse_cnt, cur_q
    );
`else
    modport master (
        output enable, cfg_valid, cfg_src_num, cfg_dst_num,
        input  cfg_ready, cfg_err, busy, cfg_loaded, clk_en_out
    );
    modport slave (
        input  enable, cfg_valid, cfg_src_num, cfg_dst_num,
        output cfg_ready, cfg_err, busy, cfg_loaded, clk_en_out
    );
`endif
endinterface

// File: rtl/frac_div_serdiv.sv
// Restoring divider producing one quotient bit per clock, MSB first.
// Latency: W cycles after start; done is high during the final step cycle.
// Backpressure: none; start may be issued at any time and restarts the division.
module frac_div_serdiv
    import frac_div_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem
);
    localparam int CW = $clog2(W + 1);

    logic [CW-1:0] steps_left;
    logic [W-1:0]  quo_r;
    logic [W-1:0]  rem_r;
    logic [W-1:0]  dvs_r;
    logic [W:0]    shifted;
    logic [W-1:0]  trial;
    logic          fits;

    // Partial remainder shifted left with the next dividend bit brought in
    assign shifted = {rem_r, quo_r[W-1]};
    assign fits    = (shifted >= {1'b0, dvs_r});
    // When it fits the difference is below the divisor, so W bits hold it exactly
    assign trial   = shifted[W-1:0] - dvs_r;

    assign done = (steps_left == CW'(1));
    assign quo  = quo_r;
    assign rem  = rem_r;

    // Load operands on start, then one restoring step per cycle; results hold afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            steps_left <= '0;
            quo_r      <= '0;
            rem_r      <= '0;
            dvs_r      <= '0;
        end else if (start) begin
            steps_left <= CW'(W);
            quo_r      <= dividend;
            rem_r      <= '0;
            dvs_r      <= divisor;
        end else if (steps_left != '0) begin
            rem_r      <= fits ? trial : shifted[W-1:0];
            quo_r      <= {quo_r[W-2:0], fits};
            steps_left <= steps_left - 1'b1;
        end
    end

endmodule

// File: rtl/frac_div_ctrl.sv
// Fractional-N clock-enable generator: DST single-cycle pulses per SRC clocks, ratio set at run time.
// Latency: accept to cfg_ready high again is W+3 cycles minimum, longer while waiting for a period end.
// Backpressure: cfg_ready low whenever the controller is not idle; offers while busy are ignored.
// Optional FRAC_DIV_CTRL_STATUS_EN adds pulse_cnt (pulses since last apply) and cur_q outputs.
module frac_div_ctrl
    import frac_div_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic            clk,
    input  logic            rst,
    frac_div_ctrl_if.slave  bus
);
    state_e        state;
    logic [W-1:0]  cap_s;
    logic [W-1:0]  cap_d;
    logic          cfg_bad;
    logic          div_start;
    logic          div_done;
    logic [W-1:0]  div_q;
    logic [W-1:0]  div_r;

    logic [W-1:0]  eng_q;
    logic [W-1:0]  eng_r;
    logic [W-1:0]  eng_d;
    logic [W-1:0]  cnt;
    logic [W-1:0]  end_val;
    logic [W:0]    acc;
    logic [W:0]    acc_sum;
    logic          acc_ge;
    logic          eng_active;
    logic          wrap;
    logic          apply;
    logic          clk_en_q;
    logic          loaded_q;

    // A ratio needs at least one output pulse and no more pulses than source cycles
    assign cfg_bad   = (cap_d == '0) || (cap_s < cap_d);
    assign div_start = (state == ST_CHECK) && !cfg_bad;
    assign apply     = (state == ST_APPLY);

    frac_div_serdiv #(.W(W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (cap_s),
        .divisor  (cap_d),
        .done     (div_done),
        .quo      (div_q),
        .rem      (div_r)
    );

    // Controller: capture the offered ratio, validate, divide, wait for a period boundary, apply
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cap_s <= '0;
            cap_d <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cfg_valid) begin
                        cap_s <= bus.cfg_src_num;
                        cap_d <= bus.cfg_dst_num;
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK:    state <= cfg_bad ? ST_IDLE : ST_CALC;
                ST_CALC:     if (div_done) state <= ST_WAIT_BND;
                // A pulse marks the start of a new period; with no running train there is nothing to wait for
                ST_WAIT_BND: if (clk_en_q || !bus.enable || !loaded_q) state <= ST_APPLY;
                ST_APPLY:    state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    // Engine period bookkeeping: acc carries the fractional part, one extra cycle each time it overflows D
    assign eng_active = bus.enable && loaded_q;
    assign wrap       = (cnt == end_val);
    assign acc_sum    = acc + {1'b0, eng_r};
    assign acc_ge     = (acc_sum >= {1'b0, eng_d});

    // Pulse engine: count to the period end, emit a pulse, choose the next period length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_q    <= '0;
            eng_r    <= '0;
            eng_d    <= '0;
            cnt      <= '0;
            end_val  <= '0;
            acc      <= '0;
            clk_en_q <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            // A period of the old ratio that ends in the apply cycle still gets its pulse
            clk_en_q <= eng_active && wrap;
            if (apply) begin
                eng_q    <= div_q;
                eng_r    <= div_r;
                eng_d    <= cap_d;
                cnt      <= '0;
                acc      <= '0;
                end_val  <= div_q - 1'b1;
                loaded_q <= 1'b1;
            end else if (!eng_active) begin
                cnt      <= '0;
                acc      <= '0;
                end_val  <= eng_q - 1'b1;
            end else if (wrap) begin
                cnt      <= '0;
                acc      <= acc_ge ? (acc_sum - {1'b0, eng_d}) : acc_sum;
                end_val  <= acc_ge ? eng_q : (eng_q - 1'b1);
            end else begin
                cnt      <= cnt + 1'b1;
            end
        end
    end

    assign bus.cfg_ready  = (state == ST_IDLE);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.cfg_err    = (state == ST_CHECK) && cfg_bad;
    assign bus.cfg_loaded = loaded_q;
    assign bus.clk_en_out = clk_en_q;

`ifdef FRAC_DIV_CTRL_STATUS_EN
    logic [15:0] pulse_cnt_q;

    // Pulse counter restarts with each applied ratio and wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_cnt_q <= '0;
        end else if (apply) begin
            pulse_cnt_q <= '0;
        end else if (clk_en_q) begin
            pulse_cnt_q <= pulse_cnt_q + 16'd1;
        end
    end

    assign bus.pulse_cnt = pulse_cnt_q;
    assign bus.cur_q     = eng_q;
`endif

endmodule

// File: tb/tb_frac_div_ctrl.sv
// Scoreboard bench for frac_div_ctrl: expected pulse gaps and error cycles are queued by
// the stimulus and consumed by a monitor that watches clk_en_out and cfg_err.
module tb_frac_div_ctrl;
    localparam int W = 8;

    typedef struct {
        bit from_ref;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t pq[$];
    int   eq[$];
    int   ref_cyc = 0;
    int   last_pulse = 0;
    bit   quiet = 1'b1;
    int   free_lo = 0;
    int   free_hi = 0;

    int   p76[5] = '{7, 8, 7, 8, 8};
    int   p94[4] = '{2, 2, 2, 3};

    frac_div_ctrl_if #(.W(W)) bus ();
    frac_div_ctrl #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endfunction

    function automatic void chk_rng(string name, int act, int lo, int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d..%0d", name, cyc, act, lo, hi);
        end
    endfunction

    function automatic void push_exp(bit fr, int v);
        exp_t e;
        e.from_ref = fr;
        e.val      = v;
        pq.push_back(e);
    endfunction

    // Monitor: every pulse is matched against the queue head, else against the free gap range
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (quiet) begin
                chk("no_pulse", int'(bus.clk_en_out), 0);
            end else if (bus.clk_en_out) begin
                if (pq.size() > 0 && !(pq[0].from_ref && cyc <= ref_cyc)) begin
                    e = pq.pop_front();
                    if (e.from_ref) chk("first_gap", cyc - ref_cyc, e.val);
                    else            chk("gap", cyc - last_pulse, e.val);
                end else if (free_hi != 0) begin
                    chk_rng("running_gap", cyc - last_pulse, free_lo, free_hi);
                end
            end
            if (bus.clk_en_out) last_pulse = cyc;
            if (bus.cfg_err) begin
                if (eq.size() > 0) chk("err_cycle", cyc, eq.pop_front());
                else               chk("err_unexpected", int'(bus.cfg_err), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a ratio for one cycle (controller must be idle), then scramble the inputs
    task automatic send_cfg(input int s, input int d, output int c);
        bus.cfg_valid   = 1'b1;
        bus.cfg_src_num = s[W-1:0];
        bus.cfg_dst_num = d[W-1:0];
        c = cyc;
        chk("ready_at_offer", int'(bus.cfg_ready), 1);
        tick();
        bus.cfg_valid   = 1'b0;
        bus.cfg_src_num = 8'hA5;
        bus.cfg_dst_num = 8'h5A;
    endtask

    task automatic wait_ready(output int rc);
        bit seen;
        seen = 1'b0;
        rc   = -1;
        for (int i = 0; i < 64 && !seen; i++) begin
            if (bus.cfg_ready) begin
                seen = 1'b1;
                rc   = cyc;
            end else begin
                tick();
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: cfg_ready 0 after 64 cycles, want 1");
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        int left;
        left = max_cyc;
        while (pq.size() > 0 && left > 0) begin
            tick();
            left--;
        end
        if (pq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d expected pulses missing, want 0", pq.size());
            pq.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int rc;

        bus.enable      = 1'b0;
        bus.cfg_valid   = 1'b0;
        bus.cfg_src_num = '0;
        bus.cfg_dst_num = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ready",  int'(bus.cfg_ready),  1);
        chk("rst_err",    int'(bus.cfg_err),    0);
        chk("rst_busy",   int'(bus.busy),       0);
        chk("rst_loaded", int'(bus.cfg_loaded), 0);
        chk("rst_clk_en", int'(bus.clk_en_out), 0);
        tick();
        rst = 1'b0;
        bus.enable = 1'b1;
        repeat (20) tick();

        // 76/10: q=7 r=6, first pulse q after apply, then gaps 7,8,7,8,8 repeating
        send_cfg(76, 10, c);
        chk("busy_after_accept", int'(bus.busy), 1);
        wait_ready(rc);
        chk("ready_low_cycles", rc - c - 1, W + 3);
        chk("loaded_after_apply", int'(bus.cfg_loaded), 1);
        quiet   = 1'b0;
        ref_cyc = rc;
        push_exp(1'b1, 7);
        for (int i = 0; i < 20; i++) push_exp(1'b0, p76[i % 5]);
        wait_drain(300);
        free_lo = 7;
        free_hi = 8;

        // Illegal ratios: one-cycle error, ready next cycle, train keeps its 7/8 gaps
        send_cfg(20, 0, c);
        eq.push_back(c + 1);
        wait_ready(rc);
        chk("err_d0_ready_back", rc - c, 2);
        repeat (20) tick();
        send_cfg(3, 7, c);
        eq.push_back(c + 1);
        wait_ready(rc);
        chk("err_s_lt_d_ready_back", rc - c, 2);
        chk("loaded_kept", int'(bus.cfg_loaded), 1);
        repeat (30) tick();

        // Enable toggle: pulses stop next cycle, restart with a first gap of q
        bus.enable = 1'b0;
        tick();
        quiet = 1'b1;
        repeat (10) tick();
        bus.enable = 1'b1;
        quiet   = 1'b0;
        ref_cyc = cyc;
        push_exp(1'b1, 7);
        for (int i = 0; i < 10; i++) push_exp(1'b0, p76[i % 5]);
        wait_drain(200);

        // Reconfigure to 4/1 mid-period; offers while busy must be ignored
        repeat (3) tick();
        send_cfg(4, 1, c);
        bus.cfg_valid   = 1'b1;
        bus.cfg_src_num = 8'd3;
        bus.cfg_dst_num = 8'd7;
        for (int i = 0; i < 4; i++) begin
            chk("ready_while_busy", int'(bus.cfg_ready), 0);
            tick();
        end
        bus.cfg_valid = 1'b0;
        wait_ready(rc);
        chk_rng("reconfig_ready_low", rc - c - 1, W + 3, W + 3 + 8);
        ref_cyc = rc;
        push_exp(1'b1, 4);
        for (int i = 0; i < 8; i++) push_exp(1'b0, 4);
        wait_drain(100);
        free_lo = 4;
        free_hi = 4;

        // 9/4: q=2 r=1, gaps 2,2,2,3
        tick();
        send_cfg(9, 4, c);
        wait_ready(rc);
        ref_cyc = rc;
        push_exp(1'b1, 2);
        for (int i = 0; i < 12; i++) push_exp(1'b0, p94[i % 4]);
        wait_drain(100);
        free_lo = 2;
        free_hi = 3;

        // 5/5: pulse every cycle
        send_cfg(5, 5, c);
        wait_ready(rc);
        ref_cyc = rc;
        push_exp(1'b1, 1);
        for (int i = 0; i < 10; i++) push_exp(1'b0, 1);
        wait_drain(100);
        free_lo = 1;
        free_hi = 1;

        // Reset during CALC: everything back to reset values, no pulses without a new ratio
        send_cfg(76, 10, c);
        repeat (3) tick();
        chk("busy_in_calc", int'(bus.busy), 1);
        #2;
        rst   = 1'b1;
        quiet = 1'b1;
        @(negedge clk);
        chk("arst_ready",  int'(bus.cfg_ready),  1);
        chk("arst_busy",   int'(bus.busy),       0);
        chk("arst_loaded", int'(bus.cfg_loaded), 0);
        chk("arst_clk_en", int'(bus.clk_en_out), 0);
        chk("arst_err",    int'(bus.cfg_err),    0);
        tick();
        rst = 1'b0;
        repeat (30) tick();
        chk("post_rst_loaded", int'(bus.cfg_loaded), 0);
        chk("post_rst_ready",  int'(bus.cfg_ready),  1);

        chk("pulse_queue_left", pq.size(), 0);
        chk("err_queue_left",   eq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
